// File: rtl/rgb_color_mask.sv
// RGB window threshold producing a binary mask plus per-frame match statistics.
// Optional bounding-box tracking is enabled with `define RGB_COLOR_MASK_BBOX_EN.
module rgb_color_mask #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned HEIGHT = 32,
    parameter logic [7:0]  R_MIN  = 8'd128,
    parameter logic [7:0]  R_MAX  = 8'd255,
    parameter logic [7:0]  G_MIN  = 8'd0,
    parameter logic [7:0]  G_MAX  = 8'd100,
    parameter logic [7:0]  B_MIN  = 8'd0,
    parameter logic [7:0]  B_MAX  = 8'd100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic        sof,
    input  logic [7:0]  Rp,
    input  logic [7:0]  Gp,
    input  logic [7:0]  Bp,
    output logic [7:0]  mask_out,
    output logic        out_valid,
    output logic [8:0]  out_col,
    output logic [8:0]  out_row,
    output logic        frame_done,
    output logic [15:0] match_count,
    output logic [23:0] x_sum,
    output logic [23:0] y_sum
`ifdef RGB_COLOR_MASK_BBOX_EN
    ,
    output logic [8:0]  bbox_xmin,
    output logic [8:0]  bbox_xmax,
    output logic [8:0]  bbox_ymin,
    output logic [8:0]  bbox_ymax,
    output logic        bbox_valid
`endif
);

    localparam logic [8:0] ColLast = 9'(WIDTH - 1);
    localparam logic [8:0] RowLast = 9'(HEIGHT - 1);

    // Borrow-based window test keeps full-range bounds from folding into constant compares.
    function automatic logic in_window(input logic [7:0] v, input logic [7:0] lo,
                                       input logic [7:0] hi);
        logic [8:0] d_lo;
        logic [8:0] d_hi;
        d_lo = {1'b0, v} - {1'b0, lo};
        d_hi = {1'b0, hi} - {1'b0, v};
        return !d_lo[8] && !d_hi[8];
    endfunction

    logic [8:0]  col_q, row_q;
    logic [15:0] cnt_q;
    logic [23:0] xs_q, ys_q;

    logic        match;
    logic        last_pix;
    logic [8:0]  cur_col, cur_row, nxt_col, nxt_row;
    logic [15:0] cnt_new;
    logic [23:0] xs_new, ys_new;

    always_comb begin
        match = in_window(Rp, R_MIN, R_MAX) && in_window(Gp, G_MIN, G_MAX) &&
                in_window(Bp, B_MIN, B_MAX);
        // sof forces this pixel to (0,0) and drops any partial-frame totals.
        cur_col  = sof ? 9'd0 : col_q;
        cur_row  = sof ? 9'd0 : row_q;
        last_pix = (cur_col == ColLast) && (cur_row == RowLast);
        if (cur_col == ColLast) begin
            nxt_col = 9'd0;
            nxt_row = last_pix ? 9'd0 : cur_row + 9'd1;
        end else begin
            nxt_col = cur_col + 9'd1;
            nxt_row = cur_row;
        end
        cnt_new = (sof ? 16'd0 : cnt_q) + (match ? 16'd1 : 16'd0);
        xs_new  = (sof ? 24'd0 : xs_q) + (match ? {15'd0, cur_col} : 24'd0);
        ys_new  = (sof ? 24'd0 : ys_q) + (match ? {15'd0, cur_row} : 24'd0);
    end

`ifdef RGB_COLOR_MASK_BBOX_EN
    logic [8:0] xmin_q, xmax_q, ymin_q, ymax_q;
    logic [8:0] xmin_base, xmax_base, ymin_base, ymax_base;
    logic [8:0] xmin_new, xmax_new, ymin_new, ymax_new;
    logic       any_match;

    always_comb begin
        xmin_base = sof ? 9'h1FF : xmin_q;
        xmax_base = sof ? 9'h000 : xmax_q;
        ymin_base = sof ? 9'h1FF : ymin_q;
        ymax_base = sof ? 9'h000 : ymax_q;
        xmin_new  = (match && cur_col < xmin_base) ? cur_col : xmin_base;
        xmax_new  = (match && cur_col > xmax_base) ? cur_col : xmax_base;
        ymin_new  = (match && cur_row < ymin_base) ? cur_row : ymin_base;
        ymax_new  = (match && cur_row > ymax_base) ? cur_row : ymax_base;
        any_match = (cnt_new != 16'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmin_q     <= 9'h1FF;
            xmax_q     <= 9'h000;
            ymin_q     <= 9'h1FF;
            ymax_q     <= 9'h000;
            bbox_xmin  <= 9'd0;
            bbox_xmax  <= 9'd0;
            bbox_ymin  <= 9'd0;
            bbox_ymax  <= 9'd0;
            bbox_valid <= 1'b0;
        end else if (pix_valid) begin
            if (last_pix) begin
                xmin_q     <= 9'h1FF;
                xmax_q     <= 9'h000;
                ymin_q     <= 9'h1FF;
                ymax_q     <= 9'h000;
                bbox_xmin  <= any_match ? xmin_new : 9'd0;
                bbox_xmax  <= any_match ? xmax_new : 9'd0;
                bbox_ymin  <= any_match ? ymin_new : 9'd0;
                bbox_ymax  <= any_match ? ymax_new : 9'd0;
                bbox_valid <= any_match;
            end else begin
                xmin_q <= xmin_new;
                xmax_q <= xmax_new;
                ymin_q <= ymin_new;
                ymax_q <= ymax_new;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= 9'd0;
            row_q       <= 9'd0;
            cnt_q       <= 16'd0;
            xs_q        <= 24'd0;
            ys_q        <= 24'd0;
            mask_out    <= 8'h00;
            out_valid   <= 1'b0;
            out_col     <= 9'd0;
            out_row     <= 9'd0;
            frame_done  <= 1'b0;
            match_count <= 16'd0;
            x_sum       <= 24'd0;
            y_sum       <= 24'd0;
        end else if (pix_valid) begin
            out_valid  <= 1'b1;
            mask_out   <= match ? 8'hFF : 8'h00;
            out_col    <= cur_col;
            out_row    <= cur_row;
            col_q      <= nxt_col;
            row_q      <= nxt_row;
            frame_done <= last_pix;
            if (last_pix) begin
                match_count <= cnt_new;
                x_sum       <= xs_new;
                y_sum       <= ys_new;
                cnt_q       <= 16'd0;
                xs_q        <= 24'd0;
                ys_q        <= 24'd0;
            end else begin
                cnt_q <= cnt_new;
                xs_q  <= xs_new;
                ys_q  <= ys_new;
            end
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rgb_color_mask.sv
// Randomized scoreboard bench for rgb_color_mask against a frame-level reference model.
module tb_rgb_color_mask;

    localparam int W = 32;
    localparam int H = 32;
    localparam int RMIN = 128, RMAX = 255, GMIN = 0, GMAX = 100, BMIN = 0, BMAX = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid, sof;
    logic [7:0]  Rp, Gp, Bp;
    logic [7:0]  mask_out;
    logic        out_valid;
    logic [8:0]  out_col, out_row;
    logic        frame_done;
    logic [15:0] match_count;
    logic [23:0] x_sum, y_sum;
`ifdef RGB_COLOR_MASK_BBOX_EN
    logic [8:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
    logic        bbox_valid;
`endif

    always #5 clk = ~clk;

    rgb_color_mask dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .Rp         (Rp),
        .Gp         (Gp),
        .Bp         (Bp),
        .mask_out   (mask_out),
        .out_valid  (out_valid),
        .out_col    (out_col),
        .out_row    (out_row),
        .frame_done (frame_done),
        .match_count(match_count),
        .x_sum      (x_sum),
        .y_sum      (y_sum)
`ifdef RGB_COLOR_MASK_BBOX_EN
        ,
        .bbox_xmin  (bbox_xmin),
        .bbox_xmax  (bbox_xmax),
        .bbox_ymin  (bbox_ymin),
        .bbox_ymax  (bbox_ymax),
        .bbox_valid (bbox_valid)
`endif
    );

    typedef struct {
        int mask;
        int col;
        int row;
        bit last;
        int cnt;
        int xs;
        int ys;
        int xmin, xmax, ymin, ymax;
        bit bv;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    logic exp_ov = 1'b0;

    // Frame-level model: position is derived from the pixel index within the frame.
    int m_idx, m_cnt, m_xs, m_ys, m_xmin, m_xmax, m_ymin, m_ymax;

    task automatic model_clear();
        m_idx = 0; m_cnt = 0; m_xs = 0; m_ys = 0;
        m_xmin = 511; m_xmax = 0; m_ymin = 511; m_ymax = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        return v < 0 ? 0 : (v > 255 ? 255 : v);
    endfunction

    function automatic int rnd_ch(input int lo, input int hi);
        case ($urandom_range(0, 5))
            0: return lo;
            1: return hi;
            2: return clamp(lo - 1);
            3: return clamp(hi + 1);
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic send(input int r, input int g, input int b, input bit s);
        exp_t e;
        bit   m;
        @(posedge clk);
        #1;
        pix_valid = 1'b1;
        sof = s;
        Rp = 8'(r); Gp = 8'(g); Bp = 8'(b);
        if (s) model_clear();
        m = (r >= RMIN && r <= RMAX) && (g >= GMIN && g <= GMAX) && (b >= BMIN && b <= BMAX);
        e.col = m_idx % W;
        e.row = m_idx / W;
        e.mask = m ? 255 : 0;
        if (m) begin
            m_cnt++;
            m_xs += e.col;
            m_ys += e.row;
            if (e.col < m_xmin) m_xmin = e.col;
            if (e.col > m_xmax) m_xmax = e.col;
            if (e.row < m_ymin) m_ymin = e.row;
            if (e.row > m_ymax) m_ymax = e.row;
        end
        m_idx++;
        e.last = (m_idx == W * H);
        e.cnt = m_cnt; e.xs = m_xs; e.ys = m_ys;
        e.bv = (m_cnt != 0);
        e.xmin = e.bv ? m_xmin : 0;
        e.xmax = e.bv ? m_xmax : 0;
        e.ymin = e.bv ? m_ymin : 0;
        e.ymax = e.bv ? m_ymax : 0;
        if (e.last) model_clear();
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof = 1'($urandom_range(0, 1));
        Rp = 8'($urandom_range(0, 255));
        Gp = 8'($urandom_range(0, 255));
        Bp = 8'($urandom_range(0, 255));
    endtask

    always @(posedge clk) exp_ov <= pix_valid;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("out_valid", 32'(out_valid), 32'(exp_ov));
                if (out_valid) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output actual=valid required=none at %0t",
                                 $time);
                    end else begin
                        e = q.pop_front();
                        check("mask_out", 32'(mask_out), 32'(e.mask));
                        check("out_col", 32'(out_col), 32'(e.col));
                        check("out_row", 32'(out_row), 32'(e.row));
                        check("frame_done", 32'(frame_done), 32'(e.last));
                        if (e.last) begin
                            check("match_count", 32'(match_count), 32'(e.cnt));
                            check("x_sum", 32'(x_sum), 32'(e.xs));
                            check("y_sum", 32'(y_sum), 32'(e.ys));
`ifdef RGB_COLOR_MASK_BBOX_EN
                            check("bbox_xmin", 32'(bbox_xmin), 32'(e.xmin));
                            check("bbox_xmax", 32'(bbox_xmax), 32'(e.xmax));
                            check("bbox_ymin", 32'(bbox_ymin), 32'(e.ymin));
                            check("bbox_ymax", 32'(bbox_ymax), 32'(e.ymax));
                            check("bbox_valid", 32'(bbox_valid), 32'(e.bv));
`endif
                        end
                    end
                end else begin
                    check("frame_done_idle", 32'(frame_done), 32'd0);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        pix_valid = 1'b0;
        sof = 1'b0;
        Rp = 8'd0; Gp = 8'd0; Bp = 8'd0;
        model_clear();

        // Reset held with random inputs: every output must stay zero.
        repeat (5) begin
            @(posedge clk);
            #1;
            pix_valid = 1'($urandom_range(0, 1));
            sof = 1'($urandom_range(0, 1));
            Rp = 8'($urandom_range(0, 255));
            Gp = 8'($urandom_range(0, 255));
            Bp = 8'($urandom_range(0, 255));
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_mask_out", 32'(mask_out), 32'd0);
            check("rst_out_col", 32'(out_col), 32'd0);
            check("rst_out_row", 32'(out_row), 32'd0);
            check("rst_frame_done", 32'(frame_done), 32'd0);
            check("rst_match_count", 32'(match_count), 32'd0);
            check("rst_x_sum", 32'(x_sum), 32'd0);
            check("rst_y_sum", 32'(y_sum), 32'd0);
`ifdef RGB_COLOR_MASK_BBOX_EN
            check("rst_bbox_valid", 32'(bbox_valid), 32'd0);
            check("rst_bbox_xmin", 32'(bbox_xmin), 32'd0);
`endif
        end
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) idle();

        // Full frame of matching pixels, continuous.
        for (int i = 0; i < W * H; i++) send(200, 50, 50, 1'b0);

        // Single red pixel at (5,3).
        for (int i = 0; i < W * H; i++) send((i == 3 * W + 5) ? 255 : 0, 0, 0, 1'b0);

        // Boundary values cycled through a whole frame.
        for (int i = 0; i < W * H; i++) begin
            case (i % 4)
                0: send(128, 100, 0, 1'b0);
                1: send(127, 100, 0, 1'b0);
                2: send(128, 101, 0, 1'b0);
                default: send(rnd_ch(RMIN, RMAX), rnd_ch(GMIN, GMAX), rnd_ch(BMIN, BMAX), 1'b0);
            endcase
        end

        // Gapped valid: one idle cycle between pixels.
        for (int i = 0; i < W * H; i++) begin
            send(200, 50, 50, 1'b0);
            idle();
        end

        // sof at pixel 300 discards the partial frame.
        for (int i = 0; i < 300; i++)
            send(rnd_ch(RMIN, RMAX), rnd_ch(GMIN, GMAX), rnd_ch(BMIN, BMAX), 1'b0);
        for (int i = 0; i < W * H; i++)
            send(rnd_ch(RMIN, RMAX), rnd_ch(GMIN, GMAX), rnd_ch(BMIN, BMAX), i == 0);

        // Random traffic with random gaps and rare sof.
        for (int i = 0; i < 2 * W * H; i++) begin
            send(rnd_ch(RMIN, RMAX), rnd_ch(GMIN, GMAX), rnd_ch(BMIN, BMAX),
                 $urandom_range(0, 699) == 0);
            if ($urandom_range(0, 3) == 0) idle();
        end

        repeat (3) idle();
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_color_mask.md
Name: rgb_color_mask

Overview:
- Downstream stage of the RGB pixel source.
- Consumes one 8-bit R/G/B pixel per valid cycle in raster order (column fastest, row slowest).
- Thresholds each channel against an inclusive window and emits a binary mask pixel with its coordinates.
- Accumulates per-frame statistics (match count, coordinate sums) for a later centroid stage, and publishes them with a one-cycle frame-done pulse.

Parameters:
- WIDTH, 32, pixels per row.
- HEIGHT, 32, rows per frame.
- R_MIN, 8'd128, inclusive lower bound, red.
- R_MAX, 8'd255, inclusive upper bound, red.
- G_MIN, 8'd0, inclusive lower bound, green.
- G_MAX, 8'd100, inclusive upper bound, green.
- B_MIN, 8'd0, inclusive lower bound, blue.
- B_MAX, 8'd100, inclusive upper bound, blue.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  Rp/Gp/Bp valid this cycle.
- sof  in  1  start of frame; meaningful only with pix_valid.
- Rp  in  8  red channel.
- Gp  in  8  green channel.
- Bp  in  8  blue channel.
- mask_out  out  8  8'hFF on match, 8'h00 otherwise.
- out_valid  out  1  mask_out, out_col and out_row valid.
- out_col  out  9  column of mask_out.
- out_row  out  9  row of mask_out.
- frame_done  out  1  one-cycle pulse; stats outputs updated.
- match_count  out  16  matched pixels in last completed frame.
- x_sum  out  24  sum of out_col over matched pixels, last frame.
- y_sum  out  24  sum of out_row over matched pixels, last frame.

Behaviour:
- Reset (async assert, sync release): all outputs 0; internal col/row counters and accumulators 0.
- Match: (R_MIN<=Rp<=R_MAX) && (G_MIN<=Gp<=G_MAX) && (B_MIN<=Bp<=B_MAX). Unsigned compare, bounds inclusive.
- Mask latency: exactly 1 cycle. Cycle after an accepted pixel:
  - out_valid=1;
  - mask_out = match result;
  - out_col/out_row = position of that pixel.
- Idle cycles: when pix_valid=0, next cycle out_valid=0. mask_out/out_col/out_row hold their previous values. Counters and accumulators hold.
- Position counters advance only on accepted pixels:
  - col increments;
  - at col==WIDTH-1: col wraps to 0, row increments;
  - at row==HEIGHT-1 with col==WIDTH-1 (last pixel): both wrap to 0.
- sof with pix_valid: the pixel is treated as position (0,0) regardless of the counters. Counters become (1,0). Accumulators restart with this pixel only; a partial frame is discarded and frame_done is not pulsed. sof without pix_valid is ignored.
- Accumulators (internal): cnt 16b, xs 24b, ys 24b. On a matched accepted pixel: cnt+=1, xs+=col, ys+=row. No saturation needed; maximums fit for default sizes.
- Last pixel accepted:
  - next cycle frame_done=1;
  - match_count/x_sum/y_sum = final totals, including the last pixel;
  - accumulators clear to 0 in the same edge.
- Stats outputs hold until the next frame_done or reset.
- frame_done is 0 in all other cycles.
- Back-to-back frames without gaps are supported. The pixel after the last one is (0,0) of the next frame and is counted in the new frame.
- Reset mid-frame: everything returns to reset values; the next accepted pixel is (0,0).

Optional Feature:
- Macro: RGB_COLOR_MASK_BBOX_EN.
- Defined: adds outputs bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax (9b each) and bbox_valid (1b).
  - Per frame, track min/max col/row of matched pixels; internal min regs start at 9'h1FF, max regs at 0.
  - Outputs update with frame_done; bbox_valid = (final count != 0).
  - With zero matches, bbox outputs are 0 and bbox_valid=0.
  - sof and reset clear the tracking, same as the accumulators.
- Undefined: no bbox ports or logic; the other ports are unchanged.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0; release, idle -> out_valid=0, frame_done=0.
- Full frame, all pixels (200,50,50), continuous pix_valid, 1024 cycles -> each mask_out=FF, 1 cycle latency. frame_done pulses the cycle after the 1024th pixel, with match_count=1024, x_sum=15872, y_sum=15872.
- Single red pixel at (col 5,row 3), all others (0,0,0) -> match_count=1, x_sum=5, y_sum=3. With BBOX_EN: bbox=(5,5,3,3), bbox_valid=1.
- Boundary values: R=128,G=100,B=0 -> FF; R=127 -> 00; G=101 -> 00.
- Gapped valid, one idle cycle between pixels -> identical stats to the continuous case; out_valid=0 in cycles after idle inputs.
- sof asserted at pixel 300 of a frame -> no frame_done until 1024 pixels after sof. Stats reflect only post-sof pixels; first output after sof is (0,0).
